// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU command sequencer.
//   - W_DEF        : datapath width (fixed at 4 to match the ALU)
//   - OP_*         : ALU select codes
//   - state_t      : sequencer FSM states
//   - entry_w()    : width of one queued command {a, b, op, use_acc}
package alu_seq_pkg;

  localparam int unsigned W_DEF = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic int unsigned entry_w(input int unsigned w);
    return 2 * w + 4;
  endfunction

  localparam int unsigned CMD_W = entry_w(W_DEF);

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: synchronous FIFO holding queued ALU commands.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_data : write request/data (ignored while full, no bypass)
//   pop, pop_data   : read request; pop_data shows the head entry
//   full, empty     : derived from the registered occupancy count
module alu_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-issue stage in front of the 4-bit ALU.
// Queues commands, drives registered operands/select to the ALU, captures
// the ALU result one cycle later and offers it on a valid/ready port.
// An accumulator holds the last result for chained (use_acc) commands.
//   cmd_*            : command input (valid/ready)
//   acc_clr          : synchronous accumulator clear (wins over capture)
//   alu_a/alu_b/alu_s: registered ALU operands and select
//   alu_y/cout/zero  : ALU combinational outputs, sampled in EXEC
//   res_*            : captured result (valid/ready)
//   busy             : FSM not idle or commands queued
// Optional: define ALU_SEQ_STATS_EN to add saturating 16-bit counters
// stat_ops (EXEC count) and stat_carry (EXEC with carry).
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [2:0]   cmd_op,
  input  logic         cmd_use_acc,
  input  logic         acc_clr,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_s,
  input  logic [W-1:0] alu_y,
  input  logic         alu_cout,
  input  logic         alu_zero,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_y,
  output logic         res_cout,
  output logic         res_zero,
  output logic         busy
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]  stat_ops,
  output logic [15:0]  stat_carry
`endif
);

  localparam int unsigned EW = entry_w(W);

  state_t        state;
  state_t        state_n;
  logic [EW-1:0] push_data;
  logic [EW-1:0] pop_data;
  logic          full;
  logic          empty;
  logic          pop;
  logic          capture;
  logic          res_clear;
  logic [W-1:0]  acc;
  logic [W-1:0]  q_a;
  logic [W-1:0]  q_b;
  logic [2:0]    q_op;
  logic          q_use_acc;

  assign push_data = {cmd_a, cmd_b, cmd_op, cmd_use_acc};
  assign q_a       = pop_data[EW-1 -: W];
  assign q_b       = pop_data[4 +: W];
  assign q_op      = pop_data[3:1];
  assign q_use_acc = pop_data[0];

  assign cmd_ready = !full;
  assign busy      = (state != ST_IDLE) || !empty;

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    capture   = 1'b0;
    res_clear = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = ST_EXEC;
        end
      end
      ST_EXEC: begin
        capture = 1'b1;
        state_n = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_clear = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            state_n = ST_EXEC;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The accumulator is written at the EXEC edge, so a use_acc pop in the
  // following HOLD already reads the freshly captured result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      res_valid <= 1'b0;
      res_y     <= '0;
      res_cout  <= 1'b0;
      res_zero  <= 1'b0;
      acc       <= '0;
    end else begin
      if (pop) begin
        alu_a <= q_use_acc ? acc : q_a;
        alu_b <= q_b;
        alu_s <= q_op;
      end
      if (capture) begin
        res_y     <= alu_y;
        res_cout  <= alu_cout;
        res_zero  <= alu_zero;
        res_valid <= 1'b1;
      end else if (res_clear) begin
        res_valid <= 1'b0;
      end
      if (acc_clr)      acc <= '0;
      else if (capture) acc <= alu_y;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops   <= '0;
      stat_carry <= '0;
    end else if (capture) begin
      if (stat_ops != '1)               stat_ops   <= stat_ops + 16'd1;
      if (alu_cout && stat_carry != '1) stat_carry <= stat_carry + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed + randomized bench for alu_op_sequencer.
// A behavioural ALU drives alu_y/cout/zero; a command queue with an
// accumulator predicts every delivered result.
module tb_alu_op_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = 4;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       use_acc;
  } cmd_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [2:0]   cmd_op = '0;
  logic         cmd_use_acc = 1'b0;
  logic         acc_clr = 1'b0;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_s;
  logic [W-1:0] alu_y;
  logic         alu_cout;
  logic         alu_zero;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_y;
  logic         res_cout;
  logic         res_zero;
  logic         busy;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]  stat_ops;
  logic [15:0]  stat_carry;
`endif

  cmd_t       q[$];
  logic [3:0] model_acc = '0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         n_acc = 0;
  int         n_del = 0;
  int         del_cyc[$];
  logic [3:0] del_y[$];
  logic [4:0] alu_out;

  always #5 clk = ~clk;

  // {cout, y} for the 4-bit ALU: add, sub (cout = no borrow), and, or,
  // xor, not a, shl by 1 (cout = a[3]), shr by 1 (cout = a[0]).
  function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} + {1'b0, ~b} + 5'd1;
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a[3], a[2:0], 1'b0};
      default: return {a[0], 1'b0, a[3:1]};
    endcase
  endfunction

  assign alu_out  = alu_ref(alu_a, alu_b, alu_s);
  assign alu_y    = alu_out[3:0];
  assign alu_cout = alu_out[4];
  assign alu_zero = (alu_out[3:0] == 4'd0);

  alu_op_sequencer #(
    .DEPTH (DEPTH),
    .W     (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .cmd_use_acc (cmd_use_acc),
    .acc_clr     (acc_clr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_s       (alu_s),
    .alu_y       (alu_y),
    .alu_cout    (alu_cout),
    .alu_zero    (alu_zero),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_y       (res_y),
    .res_cout    (res_cout),
    .res_zero    (res_zero),
    .busy        (busy)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_ops    (stat_ops),
    .stat_carry  (stat_carry)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs set: records handshakes
  // that the coming rising edge will complete, then advances one cycle.
  task automatic tick();
    cmd_t       c;
    logic [3:0] ea;
    logic [4:0] r;
    if (cmd_valid && cmd_ready) begin
      c.a = cmd_a; c.b = cmd_b; c.op = cmd_op; c.use_acc = cmd_use_acc;
      q.push_back(c);
      n_acc++;
    end
    if (res_valid && res_ready) begin
      if (q.size() == 0) begin
        check("result_without_cmd", q.size(), 1);
      end else begin
        c  = q.pop_front();
        ea = c.use_acc ? model_acc : c.a;
        r  = alu_ref(ea, c.b, c.op);
        check("result", {res_y, res_cout, res_zero}, {r[3:0], r[4], r[3:0] == 4'd0});
        model_acc = r[3:0];
        n_del++;
        del_cyc.push_back(cyc);
        del_y.push_back(res_y);
      end
    end
    if (acc_clr) model_acc = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic push1(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic use_acc);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_use_acc = use_acc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int bound);
    int n = 0;
    while (!res_valid && n < bound) begin tick(); n++; end
    check({tag, "_valid"}, res_valid, 1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (busy && n < bound) begin tick(); n++; end
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [5:0] hold;
    int         base;
    int         n;

    // Reset values
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res", {res_valid, res_y, res_cout, res_zero}, 0);
    check("rst_alu", {alu_a, alu_b, alu_s}, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Add with carry: exact two-cycle latency
    push1(4'd9, 4'd8, 3'd0, 1'b0);
    check("add_lat_e0", res_valid, 0);
    tick();
    check("add_operands", {alu_a, alu_b, alu_s}, {4'd9, 4'd8, 3'd0});
    check("add_lat_e1", res_valid, 0);
    tick();
    check("add_res", {res_valid, res_y, res_cout, res_zero}, {1'b1, 4'd1, 1'b1, 1'b0});
    tick();
    check("add_hold", {res_valid, res_y, res_cout, res_zero}, {1'b1, 4'd1, 1'b1, 1'b0});
    res_ready = 1'b1;
    tick();
    push1(4'd15, 4'd0, 3'd0, 1'b1);
    wait_res("acc_one", 10);
    check("acc_one_y", res_y, 1);
    wait_idle("acc_one", 10);

    // Subtract to zero
    push1(4'd5, 4'd5, 3'd1, 1'b0);
    wait_res("sub", 10);
    check("sub_res", {res_y, res_cout, res_zero}, {4'd0, 1'b1, 1'b1});
    wait_idle("sub", 10);

    // Accumulator chain, results two cycles apart
    push1(4'd3, 4'd4, 3'd0, 1'b0);
    push1(4'd9, 4'd2, 3'd6, 1'b1);
    wait_idle("chain", 20);
    n = del_y.size();
    check("chain_first", del_y[n-2], 7);
    check("chain_second", del_y[n-1], 14);
    check("chain_gap", del_cyc[n-1] - del_cyc[n-2], 2);

    // Backpressure / full
    res_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_a = 4'($urandom); cmd_b = 4'($urandom);
      cmd_op = 3'($urandom); cmd_use_acc = 1'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    check("bp_accepted", n_acc - base, 5);
    check("bp_cmd_ready", cmd_ready, 0);
    check("bp_res_valid", res_valid, 1);
    hold = {res_y, res_cout, res_zero};
    repeat (3) tick();
    check("bp_stable", {res_y, res_cout, res_zero}, hold);
    res_ready = 1'b1;
    base = n_del;
    wait_idle("bp", 40);
    check("bp_drained", n_del - base, 5);

    // acc_clr during EXEC: clear wins, result still captured
    res_ready = 1'b0;
    push1(4'd15, 4'd1, 3'd0, 1'b0);
    tick();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check("clr_res", {res_valid, res_y, res_cout}, {1'b1, 4'd0, 1'b1});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    push1(4'd15, 4'd2, 3'd0, 1'b0);
    tick();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check("clr2_res", {res_valid, res_y, res_cout}, {1'b1, 4'd1, 1'b1});
    res_ready = 1'b1;
    tick();
    model_acc = '0;
    push1(4'd3, 4'd6, 3'd0, 1'b1);
    wait_res("clr2_next", 10);
    check("clr2_next_y", res_y, 6);
    wait_idle("clr2", 10);

    // acc_clr while idle
    push1(4'd3, 4'd4, 3'd0, 1'b0);
    wait_idle("idleclr_pre", 10);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    push1(4'd3, 4'd5, 3'd0, 1'b1);
    wait_res("idleclr", 10);
    check("idleclr_y", res_y, 5);
    wait_idle("idleclr", 10);

    // Reset mid-HOLD drops everything asynchronously
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_a = 4'($urandom); cmd_b = 4'd0;
      cmd_op = 3'd5; cmd_use_acc = 1'b0;
      tick();
    end
    cmd_valid = 1'b0;
    wait_res("mid_rst_pre", 10);
    check("mid_rst_pre_s", alu_s, 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_alu_s", alu_s, 0);
    check("mid_rst_busy", busy, 0);
    q.delete();
    model_acc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    res_ready = 1'b1;
    push1(4'd1, 4'd9, 3'd0, 1'b1);
    wait_res("post_rst", 10);
    check("post_rst_y", res_y, 9);
    wait_idle("post_rst", 10);

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      cmd_valid   = 1'($urandom);
      cmd_a       = 4'($urandom);
      cmd_b       = 4'($urandom);
      cmd_op      = 3'($urandom);
      cmd_use_acc = 1'($urandom);
      res_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle("rand", 100);
    check("rand_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
